// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - glitch sequencer shared definitions
// Entry field positions, default widths and the sequencer state encoding.
package glitch_pkg;

  localparam int DW_DEF      = 48;
  localparam int DELAY_W_DEF = 24;
  localparam int PW_W_DEF    = 16;

  localparam int LAST_BIT    = 7;
  localparam int PW_LSB      = 8;
  localparam int PW_MSB      = PW_LSB + PW_W_DEF - 1;
  localparam int DELAY_LSB   = PW_MSB + 1;
  localparam int DELAY_MSB   = DELAY_LSB + DELAY_W_DEF - 1;

  // FETCH + LOAD cycles that overlap the gap between chained pulses
  localparam int FETCH_OVERHEAD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_FETCH,
    ST_LOAD,
    ST_DELAY,
    ST_PULSE
  } state_t;

endpackage

// File: rtl/glitch_trig_sync.sv
// rtl/glitch_trig_sync.sv - trigger rising-edge detector
// GLITCH_SEQ_TRIG_SYNC_EN adds a two-flop synchroniser ahead of the detector.
module glitch_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic rise
);

  logic trig_s;
  logic trig_d;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], trigger};
    end
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trigger;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      trig_d <= trig_s;
      rise   <= trig_s & ~trig_d;
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - FIFO-driven glitch pulse sequencer
// Optional trigger synchroniser selected by GLITCH_SEQ_TRIG_SYNC_EN (see glitch_trig_sync).
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int PW_W    = PW_W_DEF
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          ARM,
  input  logic          TRIGGER,
  input  logic [DW-1:0] FIFO_Q,
  input  logic          FIFO_EMPTY,
  output logic          FIFO_RE,
  output logic          GLITCH_OUT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR_UNDERRUN
);

  localparam int DLY_LSB = PW_LSB + PW_W;
  localparam logic [DELAY_W-1:0] OVH   = DELAY_W'(FETCH_OVERHEAD);
  localparam logic [DELAY_W-1:0] D_ONE = DELAY_W'(1);
  localparam logic [PW_W-1:0]    W_ONE = PW_W'(1);

  state_t             state, next_state;
  logic               rise;
  logic [DELAY_W-1:0] dcnt;
  logic [PW_W-1:0]    wcnt;
  logic               last_q;
  logic               first_q;
  logic [DELAY_W-1:0] q_delay;
  logic [DELAY_W-1:0] load_delay;
  logic [PW_W-1:0]    q_width;
  logic               q_last;
  logic               last_sel;
  logic               entry_end;
  logic               unused_bits;

  glitch_trig_sync u_trig (
    .clk     (CLOCK),
    .rst     (RESET),
    .trigger (TRIGGER),
    .rise    (rise)
  );

  assign q_delay     = FIFO_Q[DLY_LSB +: DELAY_W];
  assign q_width     = FIFO_Q[PW_LSB +: PW_W];
  assign q_last      = FIFO_Q[LAST_BIT];
  assign unused_bits = ^FIFO_Q[LAST_BIT-1:0];
  assign BUSY        = (state != ST_IDLE);
  assign last_sel    = (state == ST_LOAD) ? q_last : last_q;

  // Chained entries measure their delay from the end of the previous pulse,
  // so the FETCH/LOAD cycles already spent are taken off the count.
  always_comb begin
    load_delay = q_delay;
    if (!first_q) begin
      load_delay = (q_delay > OVH) ? (q_delay - OVH) : '0;
    end
  end

  always_comb begin
    next_state = state;
    FIFO_RE    = 1'b0;
    entry_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ARM) next_state = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (rise) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (FIFO_EMPTY) begin
          next_state = ST_IDLE;
        end else begin
          FIFO_RE    = 1'b1;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_delay != '0)   next_state = ST_DELAY;
        else if (q_width != '0) next_state = ST_PULSE;
        else                    entry_end  = 1'b1;
      end
      ST_DELAY: begin
        if (dcnt == D_ONE) begin
          if (wcnt != '0) next_state = ST_PULSE;
          else            entry_end  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (wcnt == W_ONE) entry_end = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
    if (entry_end) next_state = last_sel ? ST_IDLE : ST_FETCH;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      dcnt         <= '0;
      wcnt         <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b0;
      GLITCH_OUT   <= 1'b0;
      DONE         <= 1'b0;
      ERR_UNDERRUN <= 1'b0;
    end else begin
      state      <= next_state;
      GLITCH_OUT <= (next_state == ST_PULSE);
      DONE       <= entry_end & last_sel;
      if (state == ST_IDLE && ARM) begin
        ERR_UNDERRUN <= 1'b0;
      end else if (state == ST_FETCH && FIFO_EMPTY) begin
        ERR_UNDERRUN <= 1'b1;
      end
      case (state)
        ST_WAIT_TRIG: first_q <= 1'b1;
        ST_LOAD: begin
          dcnt    <= load_delay;
          wcnt    <= q_width;
          last_q  <= q_last;
          first_q <= 1'b0;
        end
        ST_DELAY: dcnt <= dcnt - D_ONE;
        ST_PULSE: wcnt <= wcnt - W_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - scoreboard bench for glitch_sequencer
// Honours GLITCH_SEQ_TRIG_SYNC_EN for the trigger-to-pulse latency.
module tb_glitch_sequencer;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        ARM = 1'b0;
  logic        TRIGGER = 1'b0;
  logic [47:0] FIFO_Q = '0;
  logic        FIFO_EMPTY;
  logic        FIFO_RE, GLITCH_OUT, BUSY, DONE, ERR_UNDERRUN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fifo_cnt = 0;
  logic [47:0] fifo_mem[$];
  logic [47:0] seq_q[$];
  int exp_re[$], exp_done[$], exp_ps[$], exp_pw[$];
  logic re_pend = 1'b0;
  logic in_pulse = 1'b0;
  int p_start = 0;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  glitch_sequencer dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .ARM          (ARM),
    .TRIGGER      (TRIGGER),
    .FIFO_Q       (FIFO_Q),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FIFO_RE      (FIFO_RE),
    .GLITCH_OUT   (GLITCH_OUT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR_UNDERRUN (ERR_UNDERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  assign FIFO_EMPTY = (fifo_cnt == 0);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] mk(input int d, input int w, input bit l);
    logic [6:0] junk;
    junk = 7'($urandom);
    return {24'(d), 16'(w), l, junk};
  endfunction

  // Upstream FIFO: data appears the cycle after a read enable
  always @(posedge CLOCK) begin
    cyc = cyc + 1;
    if (re_pend) begin
      #1;
      if (fifo_mem.size() > 0) begin
        FIFO_Q = fifo_mem.pop_front();
        fifo_cnt = fifo_mem.size();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows an event
  always @(negedge CLOCK) begin
    re_pend = FIFO_RE;
    if (FIFO_RE) begin
      if (exp_re.size() == 0) check("unexpected fifo_re", cyc, -1);
      else check("fifo_re cycle", cyc, exp_re.pop_front());
    end
    if (DONE) begin
      if (exp_done.size() == 0) check("unexpected done", cyc, -1);
      else check("done cycle", cyc, exp_done.pop_front());
    end
    if (GLITCH_OUT && !in_pulse) begin
      in_pulse = 1'b1;
      p_start = cyc;
    end else if (!GLITCH_OUT && in_pulse) begin
      in_pulse = 1'b0;
      if (exp_ps.size() == 0) check("unexpected pulse", p_start, -1);
      else begin
        check("pulse start", p_start, exp_ps.pop_front());
        check("pulse width", cyc - p_start, exp_pw.pop_front());
      end
    end
  end

  task automatic check_drained(input int left);
    check("fifo_re pending", exp_re.size(), 0);
    check("done pending", exp_done.size(), 0);
    check("pulse pending", exp_ps.size(), 0);
    check("fifo entries left", fifo_cnt, left);
    fifo_mem.delete();
    fifo_cnt = 0;
  endtask

  // Reference model: pulse start is k+LAT+D for the first entry and
  // end_of_previous + max(D,2) for chained entries.
  task automatic run_seq();
    int k, tf, st, e, d, w, left, exp_err, c;
    bit l, fin;
    @(posedge CLOCK); #1;
    foreach (seq_q[i]) fifo_mem.push_back(seq_q[i]);
    fifo_cnt = fifo_mem.size();
    ARM = 1'b1;
    @(posedge CLOCK); #1;
    ARM = 1'b0;
    check("busy after arm", BUSY, 1);
    check("err cleared by arm", ERR_UNDERRUN, 0);
    repeat ($urandom_range(0, 3)) begin @(posedge CLOCK); #1; end
    TRIGGER = 1'b1;
    k = cyc + 1;
    tf = k + LAT - 2;
    fin = 1'b0;
    left = 0;
    for (int i = 0; i < seq_q.size() && !fin; i++) begin
      d = int'(seq_q[i][47:24]);
      w = int'(seq_q[i][23:8]);
      l = seq_q[i][7];
      exp_re.push_back(tf);
      st = (i == 0) ? k + LAT + d : tf + ((d > 2) ? d : 2);
      if (w > 0) begin
        exp_ps.push_back(st);
        exp_pw.push_back(w);
      end
      e = st + w;
      if (l) begin
        exp_done.push_back(e);
        fin = 1'b1;
        left = seq_q.size() - 1 - i;
      end else begin
        tf = e;
      end
    end
    exp_err = fin ? 0 : 1;
    for (c = 0; c < 1000; c++) begin
      @(posedge CLOCK); #1;
      if (c >= 6) TRIGGER = ($urandom_range(0, 3) == 0);
      else if (c >= 1) TRIGGER = 1'b0;
      if (c > 8 && !BUSY) break;
    end
    check("sequence finished in budget", BUSY, 0);
    TRIGGER = 1'b0;
    repeat (5) begin @(posedge CLOCK); #1; end
    check("err_underrun", ERR_UNDERRUN, exp_err);
    check_drained(left);
  endtask

  initial begin
    int k, s, guard, busy_seen, n;
    bit l;
    #1 RESET = 1'b1;
    #1;
    check("reset glitch_out", GLITCH_OUT, 0);
    check("reset busy", BUSY, 0);
    check("reset done", DONE, 0);
    check("reset fifo_re", FIFO_RE, 0);
    check("reset err", ERR_UNDERRUN, 0);
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b0;
    repeat (2) begin @(posedge CLOCK); #1; end

    seq_q.delete(); seq_q.push_back(mk(5, 3, 1)); run_seq();
    seq_q.delete(); seq_q.push_back(mk(0, 1, 0)); seq_q.push_back(mk(2, 4, 1)); run_seq();
    seq_q.delete(); seq_q.push_back(mk(3, 2, 0)); run_seq();
    seq_q.delete(); seq_q.push_back(mk(0, 0, 1)); run_seq();

    // Reset in the third cycle of a 10-cycle pulse
    @(posedge CLOCK); #1;
    fifo_mem.push_back(mk(2, 10, 0));
    fifo_mem.push_back(mk(1, 1, 1));
    fifo_cnt = fifo_mem.size();
    ARM = 1'b1;
    @(posedge CLOCK); #1;
    ARM = 1'b0;
    TRIGGER = 1'b1;
    k = cyc + 1;
    s = k + LAT + 2;
    exp_re.push_back(k + LAT - 2);
    exp_ps.push_back(s);
    exp_pw.push_back(2);
    guard = 0;
    while (cyc != s + 2 && guard < 200) begin
      @(posedge CLOCK); #1;
      guard++;
      if (guard > 1) TRIGGER = 1'b0;
    end
    check("reached reset point", cyc, s + 2);
    check("glitch high before reset", GLITCH_OUT, 1);
    RESET = 1'b1;
    #1;
    check("async reset glitch_out", GLITCH_OUT, 0);
    check("async reset busy", BUSY, 0);
    check("async reset fifo_re", FIFO_RE, 0);
    check("async reset done", DONE, 0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    TRIGGER = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLOCK); #1;
      if (c == 2) TRIGGER = 1'b0;
      if (BUSY) busy_seen++;
    end
    check("busy after trigger without arm", busy_seen, 0);
    check_drained(1);

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 4);
      seq_q.delete();
      for (int i = 0; i < n; i++) begin
        l = (i == n - 1) ? ($urandom_range(0, 5) != 0) : 1'b0;
        seq_q.push_back(mk($urandom_range(0, 12), $urandom_range(0, 6), l));
      end
      if ($urandom_range(0, 1) == 1) seq_q.push_back(mk(1, 1, 1));
      run_seq();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 Parameter DW, default 48, SHALL set the FIFO entry width.
REQ-002 Parameter DELAY_W, default 24, SHALL set the delay field width.
REQ-003 Parameter PW_W, default 16, SHALL set the pulse-width field width.
REQ-004 CLOCK, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 RESET, input, 1: asynchronous, active-high reset.
REQ-006 ARM, input, 1: single-cycle request to arm the sequencer.
REQ-007 TRIGGER, input, 1: external trigger; acts on its rising edge.
REQ-008 FIFO_Q, input, DW: entry data from the upstream glitch FIFO.
REQ-009 FIFO_EMPTY, input, 1: upstream FIFO empty flag.
REQ-010 FIFO_RE, output, 1: FIFO read enable; one entry per asserted cycle.
REQ-011 GLITCH_OUT, output, 1: glitch pulse, registered.
REQ-012 BUSY, output, 1: high in any state other than IDLE.
REQ-013 DONE, output, 1: one-cycle pulse on normal sequence completion.
REQ-014 ERR_UNDERRUN, output, 1: sticky underrun error flag.

Function
REQ-015 Entry format SHALL be: [47:24] delay in cycles, [23:8] pulse width in cycles, [7] LAST, [6:0] ignored.
REQ-016 States SHALL be IDLE, WAIT_TRIG, FETCH, LOAD, DELAY and PULSE.
REQ-017 IDLE + ARM SHALL go to WAIT_TRIG and clear ERR_UNDERRUN; ARM in any other state SHALL be ignored.
REQ-018 WAIT_TRIG + detected TRIGGER rising edge SHALL go to FETCH; rising edges in every other state SHALL be ignored.
REQ-019 In FETCH with FIFO_EMPTY=0, FIFO_RE SHALL be high for exactly that one cycle (combinational from state), then the state SHALL go to LOAD.
REQ-020 In FETCH with FIFO_EMPTY=1, FIFO_RE SHALL stay low, ERR_UNDERRUN SHALL set, DONE SHALL stay low, and the state SHALL go to IDLE.
REQ-021 LOAD SHALL latch FIFO_Q, which is valid the cycle after FIFO_RE.
REQ-022 Loaded delay D SHALL hold the block in DELAY for D cycles; D=0 SHALL skip DELAY.
REQ-023 Loaded width W SHALL hold GLITCH_OUT high for exactly W consecutive cycles; W=0 SHALL produce no pulse.
REQ-024 Without the synchroniser, the first high cycle of GLITCH_OUT SHALL be k+3+D, where k is the cycle the rising edge is sampled.
REQ-025 After the pulse, LAST=1 SHALL pulse DONE and go to IDLE; LAST=0 SHALL go to FETCH, and the next delay SHALL count from the end of the previous pulse.
REQ-026 Counters SHALL be down-counters of DELAY_W and PW_W bits; a field value of all-ones is legal and SHALL NOT wrap.

Reset
REQ-027 RESET high SHALL immediately force the state to IDLE and GLITCH_OUT, FIFO_RE, BUSY, DONE and ERR_UNDERRUN to 0, including mid-pulse.
REQ-028 This block SHALL NOT reset the FIFO; a partial sequence leaves unread entries in the FIFO.

Configuration
REQ-029 With GLITCH_SEQ_TRIG_SYNC_EN defined, TRIGGER SHALL pass through a two-flop synchroniser before edge detection, adding 2 cycles (first pulse cycle k+5+D).
REQ-030 Without GLITCH_SEQ_TRIG_SYNC_EN, TRIGGER SHALL be registered once for edge detection only, and the latency of REQ-024 applies.

Structure
REQ-031 Package glitch_pkg SHALL hold the field bit positions, DELAY_W/PW_W defaults and the state enumeration.
REQ-032 Sub-module glitch_trig_sync SHALL contain the optional synchroniser and the rising-edge detector.

Verification
REQ-033 Scenario 1: one entry {D=5, W=3, LAST=1}, ARM, then TRIGGER, no sync → GLITCH_OUT high on cycles k+8..k+10 and DONE at k+11.
REQ-034 Scenario 2: entries {0,1,0} and {2,4,1} → a 1-cycle pulse, 2 idle cycles, a 4-cycle pulse, two FIFO_RE pulses and one DONE.
REQ-035 Scenario 3: first entry LAST=0, then FIFO empty → ERR_UNDERRUN=1, state IDLE, no DONE; ERR_UNDERRUN clears on the next ARM.
REQ-036 Scenario 4: entry {D=0, W=0, LAST=1} → GLITCH_OUT never high and DONE asserted.
REQ-037 Scenario 5: RESET asserted during the 3rd cycle of a W=10 pulse → GLITCH_OUT low asynchronously, BUSY=0, and TRIGGER without ARM ignored afterwards.
REQ-038 Scenario 6: rebuild with GLITCH_SEQ_TRIG_SYNC_EN and repeat Scenario 1 → pulse shifted by exactly 2 cycles.
